// File: rtl/md_execute_stage.sv
// Iterative signed multiply/divide execute unit: one radix-2 step per cycle,
// stalling the pipeline until the result is ready.
module md_execute_stage (
    input  logic        clock,
    input  logic        clr,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [11:0] tag_in,
    output logic        stall,
    output logic        busy,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_rdy,
    output logic [11:0] tag_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_cnt;
    logic        r_fin;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;
    logic        r_negA;
    logic        r_negB;
    logic [11:0] r_tag;

    logic        w_startOne;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [32:0] w_mulSum;
    logic [32:0] w_divPart;
    logic [31:0] w_divSub;
    logic        w_divFits;
    logic        w_neg;
    logic [63:0] w_prodMag;
    logic [63:0] w_prodSigned;
    logic        w_mulOvf;
    logic [31:0] w_quoSigned;
    logic [31:0] w_divRes;
    logic        w_divExc;

    assign w_startOne = start_mult ^ start_div;

    // Magnitudes are taken at the start edge; 0x80000000 maps to 2^31 unsigned.
    assign w_absA = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    assign w_absB = operand_b[31] ? (32'd0 - operand_b) : operand_b;

    // Multiply: {r_hi, r_lo} is the product register, r_lo starts as the multiplier.
    assign w_mulSum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : 32'd0)};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_divPart = {r_hi, r_lo[31]};
    assign w_divFits = (w_divPart >= {1'b0, r_b});
    assign w_divSub  = w_divPart[31:0] - r_b;

    assign w_neg        = r_negA ^ r_negB;
    assign w_prodMag    = {r_hi, r_lo};
    assign w_prodSigned = w_neg ? (64'd0 - w_prodMag) : w_prodMag;
    assign w_mulOvf     = (w_prodSigned[63:32] != {32{w_prodSigned[31]}});

    // Only a positive 2^31 quotient (MIN / -1) cannot be represented.
    assign w_quoSigned = w_neg ? (32'd0 - r_lo) : r_lo;
    assign w_divRes    = (r_b == 32'd0) ? 32'd0 : w_quoSigned;
    assign w_divExc    = (r_b == 32'd0) || (!w_neg && r_lo[31]);

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_mult && !start_div) begin
                    w_next = MULT;
                end else if (start_div && !start_mult) begin
                    w_next = DIV;
                end
            end
            MULT, DIV: begin
                if (r_fin) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // After the 32nd step r_fin is set; the following cycle applies signs and publishes.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            r_cnt     <= 5'd0;
            r_fin     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_b       <= 32'd0;
            r_negA    <= 1'b0;
            r_negB    <= 1'b0;
            r_tag     <= 12'd0;
            result    <= 32'd0;
            exception <= 1'b0;
            tag_out   <= 12'd0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_startOne) begin
                        r_cnt  <= 5'd0;
                        r_fin  <= 1'b0;
                        r_hi   <= 32'd0;
                        r_lo   <= w_absA;
                        r_b    <= w_absB;
                        r_negA <= operand_a[31];
                        r_negB <= operand_b[31];
                        r_tag  <= tag_in;
                    end
                end
                MULT: begin
                    if (!r_fin) begin
                        r_hi  <= w_mulSum[32:1];
                        r_lo  <= {w_mulSum[0], r_lo[31:1]};
                        r_cnt <= r_cnt + 5'd1;
                        r_fin <= (r_cnt == 5'd31);
                    end else begin
                        result    <= w_prodSigned[31:0];
                        exception <= w_mulOvf;
                        tag_out   <= r_tag;
                    end
                end
                DIV: begin
                    if (!r_fin) begin
                        if (w_divFits) begin
                            r_hi <= w_divSub;
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_divPart[31:0];
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 5'd1;
                        r_fin <= (r_cnt == 5'd31);
                    end else begin
                        result    <= w_divRes;
                        exception <= w_divExc;
                        tag_out   <= r_tag;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall      = ((r_state == IDLE) && w_startOne) || (r_state == MULT) || (r_state == DIV);
    assign busy       = (r_state != IDLE);
    assign result_rdy = (r_state == DONE);

endmodule

// File: tb/tb_md_execute_stage.sv
// Directed self-checking bench for md_execute_stage: hand-computed products and
// quotients, latency/stall counting, ignored starts and mid-operation reset.
module tb_md_execute_stage;

    logic        clock;
    logic        clr;
    logic        start_mult;
    logic        start_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [11:0] tag_in;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        exception;
    logic        result_rdy;
    logic [11:0] tag_out;

    int nChecks = 0;
    int nFails  = 0;

    md_execute_stage dut (
        .clock      (clock),
        .clr        (clr),
        .start_mult (start_mult),
        .start_div  (start_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .tag_in     (tag_in),
        .stall      (stall),
        .busy       (busy),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .tag_out    (tag_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", name, obs, exp);
        end
    endtask

    // Called at a falling edge; drives one start, scrambles inputs after the start
    // edge, and measures edges-to-result and stall cycles.
    task automatic applyStimulus(input logic isMult, input logic [31:0] a, input logic [31:0] b,
                                 input logic [11:0] tag, input logic [31:0] expRes,
                                 input logic expExc, input logic glitch, input string name);
        int edges;
        int stallCnt;
        start_mult = isMult;
        start_div  = !isMult;
        operand_a  = a;
        operand_b  = b;
        tag_in     = tag;
        #1;
        checkOutput({name, " start stall"}, {31'd0, stall}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = $urandom;
        operand_b  = $urandom;
        tag_in     = 12'($urandom);
        edges    = 0;
        stallCnt = 0;
        while (!result_rdy && edges < 60) begin
            if (stall) stallCnt++;
            if (glitch) begin
                start_mult = 1'($urandom_range(0, 1));
                start_div  = 1'($urandom_range(0, 1));
            end
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        start_mult = 1'b0;
        start_div  = 1'b0;
        checkOutput({name, " rdy seen"}, {31'd0, result_rdy}, 32'd1);
        checkOutput({name, " latency"}, edges, 32'd33);
        checkOutput({name, " stall cycles"}, stallCnt, 32'd33);
        checkOutput({name, " done stall"}, {31'd0, stall}, 32'd0);
        checkOutput({name, " result"}, result, expRes);
        checkOutput({name, " exception"}, {31'd0, exception}, {31'd0, expExc});
        checkOutput({name, " tag_out"}, {20'd0, tag_out}, {20'd0, tag});
        @(negedge clock);
        checkOutput({name, " rdy one cycle"}, {31'd0, result_rdy}, 32'd0);
        checkOutput({name, " idle busy"}, {31'd0, busy}, 32'd0);
        checkOutput({name, " result held"}, result, expRes);
    endtask

    initial begin
        int rdyCnt;
        int busyCnt;
        clr        = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        operand_a  = 32'd0;
        operand_b  = 32'd0;
        tag_in     = 12'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset exception", {31'd0, exception}, 32'd0);
        checkOutput("reset rdy", {31'd0, result_rdy}, 32'd0);
        checkOutput("reset tag_out", {20'd0, tag_out}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset stall", {31'd0, stall}, 32'd0);
        clr = 1'b0;

        @(negedge clock);
        applyStimulus(1'b1, 32'd6, 32'd7, 12'h123, 32'd42, 1'b0, 1'b0, "mul 6x7");
        applyStimulus(1'b1, 32'hFFFFFFFD, 32'd5, 12'h0A1, 32'hFFFFFFF1, 1'b0, 1'b0, "mul -3x5");
        applyStimulus(1'b1, 32'h00010000, 32'h00010000, 12'h0A2, 32'h00000000, 1'b1, 1'b0, "mul ovf");
        applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2, 12'h0B1, 32'hFFFFFFFD, 1'b0, 1'b0, "div -7/2");
        applyStimulus(1'b0, 32'd5, 32'd0, 12'h0B2, 32'd0, 1'b1, 1'b0, "div by zero");
        applyStimulus(1'b0, 32'h80000000, 32'hFFFFFFFF, 12'h0B3, 32'h80000000, 1'b1, 1'b0, "div min/-1");
        applyStimulus(1'b1, 32'h80000000, 32'd1, 12'h0C1, 32'h80000000, 1'b0, 1'b0, "mul min x1");
        applyStimulus(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0C2, 32'd1, 1'b0, 1'b1, "mul glitch");

        // Any stray completion after the glitched multiply would be a second pulse.
        rdyCnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (result_rdy) rdyCnt++;
        end
        checkOutput("glitch single rdy", rdyCnt, 32'd0);

        start_mult = 1'b1;
        start_div  = 1'b1;
        operand_a  = 32'd9;
        operand_b  = 32'd3;
        #1;
        checkOutput("both starts stall", {31'd0, stall}, 32'd0);
        rdyCnt  = 0;
        busyCnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (result_rdy) rdyCnt++;
            if (busy) busyCnt++;
        end
        checkOutput("both starts rdy", rdyCnt, 32'd0);
        checkOutput("both starts busy", busyCnt, 32'd0);
        start_mult = 1'b0;
        start_div  = 1'b0;

        @(negedge clock);
        applyStimulus(1'b0, 32'd100, 32'hFFFFFFF9, 12'h5A5, 32'hFFFFFFF2, 1'b0, 1'b0, "div 100/-7");

        // Divide interrupted by clr after its tenth iteration edge.
        start_div = 1'b1;
        operand_a = 32'd1000;
        operand_b = 32'd7;
        tag_in    = 12'h777;
        @(posedge clock);
        @(negedge clock);
        start_div = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        checkOutput("pre-clr busy", {31'd0, busy}, 32'd1);
        clr = 1'b1;
        #1;
        checkOutput("clr busy", {31'd0, busy}, 32'd0);
        checkOutput("clr stall", {31'd0, stall}, 32'd0);
        checkOutput("clr result", result, 32'd0);
        checkOutput("clr tag_out", {20'd0, tag_out}, 32'd0);
        checkOutput("clr rdy", {31'd0, result_rdy}, 32'd0);
        rdyCnt = 0;
        repeat (2) begin
            @(negedge clock);
            if (result_rdy) rdyCnt++;
        end
        checkOutput("clr no rdy", rdyCnt, 32'd0);
        clr = 1'b0;
        applyStimulus(1'b1, 32'd3, 32'd4, 12'h034, 32'd12, 1'b0, 1'b0, "mul 3x4 after clr");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/md_execute_stage.md
MD_EXECUTE_STAGE -- requirements
Module: md_execute_stage

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: clr  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start_mult  input  1  request signed multiply of operand_a by operand_b.
REQ-004 SHALL have port: start_div  input  1  request signed divide of operand_a by operand_b.
REQ-005 SHALL have port: operand_a  input  32  first operand, from the D/X stage register.
REQ-006 SHALL have port: operand_b  input  32  second operand, from the D/X stage register.
REQ-007 SHALL have port: tag_in  input  12  instruction tag (PC/destination info) travelling with the operation.
REQ-008 SHALL have port: stall  output  1  hold request; upstream stage registers use w_en = ~stall.
REQ-009 SHALL have port: busy  output  1  unit not in IDLE.
REQ-010 SHALL have port: result  output  32  low 32 bits of product, or quotient.
REQ-011 SHALL have port: exception  output  1  overflow or divide-by-zero flag for the completed operation.
REQ-012 SHALL have port: result_rdy  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: tag_out  output  12  tag_in captured at start, returned with the result.

Function
REQ-014 SHALL implement states IDLE, MULT, DIV and DONE, plus a 5-bit iteration counter.
REQ-015 SHALL sample a start only in IDLE: start_mult alone -> MULT; start_div alone -> DIV; on that edge operand_a, operand_b and tag_in are latched and the counter is cleared.
REQ-016 SHALL ignore a start when start_mult and start_div are both high; the unit stays in IDLE and stall stays 0.
REQ-017 SHALL ignore start_mult and start_div in MULT, DIV and DONE; changes to operands or tag after the start edge SHALL have no effect.
REQ-018 SHALL perform one radix-2 iteration per cycle in MULT and in DIV: a shift-add multiply on magnitudes and a restoring divide on magnitudes, with sign fixed after iteration 31.
REQ-019 SHALL leave MULT or DIV for DONE after exactly 32 iterations, so result_rdy is high in the cycle after start edge +33; DONE lasts one cycle and then returns to IDLE.
REQ-020 SHALL make multiply produce the low 32 bits of the signed 64-bit product, with exception=1 if and only if the 64-bit product is not the sign-extension of those 32 bits.
REQ-021 SHALL make divide produce a signed quotient truncated toward zero, discarding the remainder.
REQ-022 SHALL handle divide with operand_b=0 as result=0 and exception=1, with the same 33-cycle latency.
REQ-023 SHALL handle 0x80000000 / 0xFFFFFFFF as result=0x80000000 and exception=1.
REQ-024 SHALL drive stall combinationally = (IDLE and exactly one start high) or state in {MULT, DIV}; stall SHALL be 0 in DONE so the pipeline advances and captures result.
REQ-025 SHALL drive busy = (state != IDLE).
REQ-026 SHALL update result, exception and tag_out only when entering DONE, and hold them until the next completion.
REQ-027 SHALL assert result_rdy only in DONE.

Reset
REQ-028 SHALL, while clr is high and independent of clock, force state to IDLE, the counter to 0, and result, exception, result_rdy and tag_out to 0; stall and busy SHALL then be 0.
REQ-029 SHALL abandon an operation interrupted by clr mid-operation with no result_rdy pulse; the first rising edge after clr falls SHALL again accept a start.

Verification
REQ-030 SHALL verify: start_mult with 6, 7, tag 0x123 -> stall high for 33 cycles, result_rdy in cycle 33, result=42, exception=0, tag_out=0x123.
REQ-031 SHALL verify: start_mult with 0xFFFFFFFD, 5 -> result=0xFFFFFFF1, exception=0; and with 0x00010000, 0x00010000 -> result=0x00000000, exception=1.
REQ-032 SHALL verify: start_div with 0xFFFFFFF9 (-7), 2 -> result=0xFFFFFFFD, exception=0, latency 33.
REQ-033 SHALL verify: start_div with 5, 0 -> result=0, exception=1; then 0x80000000 / 0xFFFFFFFF -> result=0x80000000, exception=1.
REQ-034 SHALL verify: start_mult and start_div high together in IDLE -> busy=0, stall=0, no result_rdy within 40 cycles; start pulses during MULT are ignored, giving exactly one result_rdy.
REQ-035 SHALL verify: clr asserted at iteration 10 of a divide -> busy, stall and outputs 0 immediately; no result_rdy; a new multiply 3 x 4 after release -> 12 at +33.
